// File: rtl/matrix_mac_engine.sv
// Lane-parallel unsigned multiply with element-wise or dot-product reduction, saturating accumulate
// and a DEPTH-entry result buffer; 4-cycle op (start, MUL, SUM, WRITE), starts ignored while busy or full.
module matrix_mac_engine #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [LANES*W-1:0]     multiplier_input,
  input  logic [LANES*W-1:0]     multiplicand_input,
  input  logic                   mStart,
  input  logic                   Add,
  input  logic                   Acc,
  input  logic                   direct,
  input  logic                   bufferRD,
  input  logic [AW-1:0]          AddressSelect,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic [LANES*ACC_W-1:0] flatsumout
);

  typedef enum logic [1:0] {IDLE, MUL, SUM, WRITE} state_t;
  typedef logic [LANES-1:0][ACC_W-1:0] vec_t;

  state_t           state_q, state_d;
  logic [LANES*W-1:0] a_q, b_q;
  logic             add_q, accm_q;
  vec_t             prod_q, prod_d;
  vec_t             acc_q, acc_d;
  vec_t             rd_q;
  vec_t             buf_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             start;
  logic [ACC_W:0]   total;
  logic [ACC_W:0]   lane_sum;
  logic [2*W-1:0]   mul;

  function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == WRITE);
  assign start = (state_q == IDLE) && mStart && !full;
  assign flatsumout = direct ? acc_q : rd_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     state_d = SUM;
      SUM:     state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_d = '0;
    mul    = '0;
    for (int i = 0; i < LANES; i++) begin
      mul       = {{W{1'b0}}, a_q[i*W +: W]} * {{W{1'b0}}, b_q[i*W +: W]};
      prod_d[i] = {{(ACC_W-2*W){1'b0}}, mul};
    end
  end

  // Sums carry one extra bit so overflow is detected and clamped instead of wrapping.
  always_comb begin
    acc_d    = acc_q;
    total    = '0;
    lane_sum = '0;
    if (state_q == SUM) begin
      if (add_q) begin
        total = accm_q ? {1'b0, acc_q[0]} : '0;
        for (int i = 0; i < LANES; i++) total = total + {1'b0, prod_q[i]};
        acc_d    = '0;
        acc_d[0] = sat(total);
      end else begin
        for (int i = 0; i < LANES; i++) begin
          lane_sum = (accm_q ? {1'b0, acc_q[i]} : '0) + {1'b0, prod_q[i]};
          acc_d[i] = sat(lane_sum);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      add_q    <= 1'b0;
      accm_q   <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      rd_q     <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (start) begin
        a_q    <= multiplier_input;
        b_q    <= multiplicand_input;
        add_q  <= Add;
        accm_q <= Acc;
      end
      if (state_q == MUL) prod_q <= prod_d;
      // count_q is the pre-write value here, so a same-cycle read of the slot being written returns 0.
      if (bufferRD)
        rd_q <= ({1'b0, AddressSelect} < count_q) ? buf_q[AddressSelect] : '0;
      if (state_q == WRITE) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && state_q == WRITE) buf_q[wr_ptr_q] <= acc_q;
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: per-cycle comparison against a result-level model plus
// hand-computed literal expectations for the default parameters.
module tb_matrix_mac_engine;
  localparam int LANES = 4, W = 8, ACC_W = 20, DEPTH = 16;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] multiplier_input = '0, multiplicand_input = '0;
  logic        mStart = 0, Add = 0, Acc = 0, direct = 0, bufferRD = 0;
  logic [3:0]  AddressSelect = '0;
  logic        busy, done, full;
  logic [79:0] flatsumout;

  always #5 Clk = ~Clk;

  matrix_mac_engine #(.LANES(LANES), .W(W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .multiplier_input(multiplier_input), .multiplicand_input(multiplicand_input),
    .mStart(mStart), .Add(Add), .Acc(Acc), .direct(direct),
    .bufferRD(bufferRD), .AddressSelect(AddressSelect),
    .busy(busy), .done(done), .full(full), .flatsumout(flatsumout)
  );

  int total = 0, bad = 0, done_cnt = 0, dc0 = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result-level model: an accepted start yields its full result immediately; it becomes
  // visible in acc two edges later and lands in the buffer one edge after that.
  int          age = 0, m_cnt = 0, m_wp = 0;
  logic [79:0] m_acc = '0, m_rd = '0, pend = '0;
  logic [79:0] m_buf [DEPTH];

  function automatic logic [79:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic add, input logic acc, input logic [79:0] cur);
    logic [79:0] r;
    longint tot, p, s;
    r = '0;
    tot = acc ? longint'(cur[19:0]) : 0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'(a[i*8 +: 8]) * longint'(b[i*8 +: 8]);
      if (add) tot += p;
      else begin
        s = (acc ? longint'(cur[i*20 +: 20]) : 0) + p;
        r[i*20 +: 20] = (s > MAXV) ? 20'(MAXV) : 20'(s);
      end
    end
    if (add) r[19:0] = (tot > MAXV) ? 20'(MAXV) : 20'(tot);
    return r;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      age = 0; m_cnt = 0; m_wp = 0; m_acc = '0; m_rd = '0;
    end else begin
      if (bufferRD) m_rd = (int'(AddressSelect) < m_cnt) ? m_buf[AddressSelect] : '0;
      if (age == 0) begin
        if (mStart && m_cnt < DEPTH) begin
          pend = model_op(multiplier_input, multiplicand_input, Add, Acc, m_acc);
          age = 1;
        end
      end else if (age == 1) age = 2;
      else if (age == 2) begin m_acc = pend; age = 3; end
      else begin
        m_buf[m_wp] = m_acc; m_wp++; m_cnt++; age = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (done === 1'b1) done_cnt++;
    if (chk_en) begin
      chk("busy", 80'(busy), 80'(age != 0));
      chk("done", 80'(done), 80'(age == 3));
      chk("full", 80'(full), 80'(m_cnt == DEPTH));
      chk("flatsumout", flatsumout, direct ? m_acc : m_rd);
    end
  end

  localparam logic [31:0] OPA = 32'h0301_1000;
  localparam logic [31:0] OPB = 32'h0101_0101;
  localparam logic [79:0] R_EW = 80'h00003_00001_00010_00000;

  task automatic step(); @(posedge Clk); #2; endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic add, input logic acc);
    multiplier_input = a; multiplicand_input = b; Add = add; Acc = acc; mStart = 1;
    step();
    mStart = 0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic add, input logic acc);
    start_op(a, b, add, acc);
    step(); step(); step();
  endtask

  task automatic reset_dut();
    Rst = 1; step(); Rst = 0;
  endtask

  initial begin
    // reset with start held high
    Rst = 1; mStart = 1;
    step(); chk_en = 1'b1; step();
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_flat", flatsumout, 80'(0));
    chk("rst_full_done", 80'({full, done}), 80'(0));
    mStart = 0; Rst = 0; direct = 1;

    // element-wise, done three cycles after start
    dc0 = done_cnt;
    start_op(OPA, OPB, 0, 0);
    step(); chk("ew_done_early", 80'(done), 80'(0));
    step(); chk("ew_done_e2", 80'(done), 80'(1));
    chk("ew_lanes", flatsumout, R_EW);
    step(); chk("ew_done_once", 80'(done_cnt - dc0), 80'(1));

    // reduce, then accumulate with a spurious start while busy
    do_op(OPA, OPB, 1, 0);
    chk("reduce", flatsumout, 80'h14);
    dc0 = done_cnt;
    start_op(OPA, OPB, 1, 1);
    mStart = 1; step(); step(); step(); mStart = 0;
    step();
    chk("reduce_acc", flatsumout, 80'h28);
    chk("one_done_per_start", 80'(done_cnt - dc0), 80'(1));

    // saturation
    reset_dut();
    begin
      logic [79:0] sat_exp [5];
      sat_exp[0] = 80'h3F804; sat_exp[1] = 80'h7F008; sat_exp[2] = 80'hBE80C;
      sat_exp[3] = 80'hFE010; sat_exp[4] = 80'hFFFFF;
      for (int k = 0; k < 5; k++) begin
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
        chk($sformatf("sat_op%0d", k + 1), flatsumout, sat_exp[k]);
      end
    end

    // buffer readback
    reset_dut();
    direct = 0;
    do_op(OPA, OPB, 0, 0);
    do_op(OPA, OPB, 1, 0);
    bufferRD = 1; AddressSelect = 4'd0; step();
    chk("rd_addr0", flatsumout, R_EW);
    AddressSelect = 4'd1; step();
    chk("rd_addr1", flatsumout, 80'h14);
    AddressSelect = 4'd5; step();
    chk("rd_addr5", flatsumout, 80'h0);
    bufferRD = 0; AddressSelect = 4'd0; step();
    chk("rd_hold", flatsumout, 80'h0);
    start_op(OPA, OPB, 1, 1);
    step(); step();
    bufferRD = 1; AddressSelect = 4'd2; step();
    chk("rd_during_write", flatsumout, 80'h0);
    step();
    chk("rd_addr2_after", flatsumout, 80'h28);
    bufferRD = 0;

    // fill to DEPTH
    reset_dut();
    direct = 1;
    dc0 = done_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == DEPTH - 1) chk("not_full_15", 80'(full), 80'(0));
      do_op(OPA, OPB, 0, 0);
    end
    chk("full_16", 80'(full), 80'(1));
    chk("dones_16", 80'(done_cnt - dc0), 80'(DEPTH));
    dc0 = done_cnt;
    mStart = 1;
    for (int k = 0; k < 4; k++) begin
      step(); chk("full_no_busy", 80'(busy), 80'(0));
    end
    mStart = 0;
    chk("full_no_done", 80'(done_cnt - dc0), 80'(0));

    // reset mid-operation
    reset_dut();
    dc0 = done_cnt;
    start_op(OPA, OPB, 1, 0);
    Rst = 1; step(); Rst = 0;
    step(); step(); step(); step();
    chk("midrst_no_done", 80'(done_cnt - dc0), 80'(0));
    chk("midrst_full", 80'(full), 80'(0));
    do_op(OPA, OPB, 0, 0);
    direct = 0; bufferRD = 1; AddressSelect = 4'd0; step();
    chk("midrst_addr0", flatsumout, R_EW);
    AddressSelect = 4'd1; step();
    chk("midrst_addr1", flatsumout, 80'h0);
    bufferRD = 0; step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
